// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Main control FSM for the multi-cycle MIPS datapath. It decodes the opcode held
// in the instruction register and steps the datapath through fetch, decode,
// execute, memory and write-back. It also drives the 3-bit alu_op consumed by
// ALU_CONTROL.
// Optional feature: define CTRL_ADDI_EN to decode addi through the
// ADDI_EX/ADDI_WB states. Without it, addi is reported as an illegal opcode.
// Reset is synchronous and active-high. While reset is high every output reads 0,
// so a reset asserted mid-instruction cannot leave a write strobe active.

module mips_multicycle_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done,
  output logic       o_illegal_op,
  output logic [3:0] o_state
);

  // Opcodes recognised in DECODE
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // Encodings handed to ALU_CONTROL
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State codes. These are also exported on o_state for debug.
  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
`ifdef CTRL_ADDI_EN
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;
`endif

  logic [3:0] r_state;
  logic [3:0] w_nextState;

  logic       w_pcWrite;
  logic       w_pcWriteCond;
  logic       w_iOrD;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_memToReg;
  logic       w_regDst;
  logic       w_regWrite;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [2:0] w_aluOp;
  logic [1:0] w_pcSource;
  logic       w_instrDone;
  logic       w_illegalOp;
  logic       w_run;

  // State register; reset wins on any edge, including mid-instruction
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: mem_ready only matters in the three memory-access states
  always_comb begin
    w_nextState = S_RST;
    case (r_state)
      S_RST: begin
        w_nextState = S_FETCH;
      end
      S_FETCH: begin
        w_nextState = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE: w_nextState = S_EXEC;
          OP_LW:    w_nextState = S_MEM_ADDR;
          OP_SW:    w_nextState = S_MEM_ADDR;
          OP_BEQ:   w_nextState = S_BRANCH;
          OP_J:     w_nextState = S_JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:  w_nextState = S_ADDI_EX;
`endif
          default:  w_nextState = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        w_nextState = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_nextState = i_mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        w_nextState = S_FETCH;
      end
      S_MEM_WR: begin
        w_nextState = i_mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC: begin
        w_nextState = S_R_WB;
      end
      S_R_WB: begin
        w_nextState = S_FETCH;
      end
      S_BRANCH: begin
        w_nextState = S_FETCH;
      end
      S_JUMP: begin
        w_nextState = S_FETCH;
      end
`ifdef CTRL_ADDI_EN
      S_ADDI_EX: begin
        w_nextState = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_nextState = S_FETCH;
      end
`endif
      default: begin
        w_nextState = S_RST;
      end
    endcase
  end

  // Output decode: each state raises only its own controls, everything else stays 0
  always_comb begin
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_iOrD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_memToReg    = 1'b0;
    w_regDst      = 1'b0;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = SRCB_REG;
    w_aluOp       = ALU_ADD;
    w_pcSource    = PCSRC_ALU;
    w_instrDone   = 1'b0;
    w_illegalOp   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memRead  = 1'b1;
        w_aluSrcB  = SRCB_FOUR;
        w_aluOp    = ALU_ADD;
        w_pcSource = PCSRC_ALU;
        w_irWrite  = i_mem_ready;
        w_pcWrite  = i_mem_ready;
      end
      S_DECODE: begin
        w_aluSrcB = SRCB_IMMSH;
        w_aluOp   = ALU_ADD;
        case (i_opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: w_illegalOp = 1'b0;
`ifdef CTRL_ADDI_EN
          OP_ADDI: w_illegalOp = 1'b0;
`endif
          default: w_illegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = SRCB_IMM;
        w_aluOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        w_memRead = 1'b1;
        w_iOrD    = 1'b1;
      end
      S_MEM_WB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = 1'b1;
        w_regDst    = 1'b0;
        w_instrDone = 1'b1;
      end
      S_MEM_WR: begin
        w_memWrite  = 1'b1;
        w_iOrD      = 1'b1;
        w_instrDone = i_mem_ready;
      end
      S_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = SRCB_REG;
        w_aluOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b1;
        w_memToReg  = 1'b0;
        w_instrDone = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA     = 1'b1;
        w_aluSrcB     = SRCB_REG;
        w_aluOp       = ALU_SUB;
        w_pcWriteCond = 1'b1;
        w_pcSource    = PCSRC_ALUOUT;
        w_instrDone   = 1'b1;
      end
      S_JUMP: begin
        w_pcWrite   = 1'b1;
        w_pcSource  = PCSRC_JUMP;
        w_instrDone = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      S_ADDI_EX: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = SRCB_IMM;
        w_aluOp   = ALU_ADD;
      end
      S_ADDI_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b0;
        w_memToReg  = 1'b0;
        w_instrDone = 1'b1;
      end
`endif
      default: begin
        w_illegalOp = 1'b0;
      end
    endcase
  end

  // Hold every output at 0 while reset is asserted, whatever state we were in
  assign w_run = ~i_reset;

  assign o_pc_write      = w_pcWrite     & w_run;
  assign o_pc_write_cond = w_pcWriteCond & w_run;
  assign o_i_or_d        = w_iOrD        & w_run;
  assign o_mem_read      = w_memRead     & w_run;
  assign o_mem_write     = w_memWrite    & w_run;
  assign o_ir_write      = w_irWrite     & w_run;
  assign o_mem_to_reg    = w_memToReg    & w_run;
  assign o_reg_dst       = w_regDst      & w_run;
  assign o_reg_write     = w_regWrite    & w_run;
  assign o_alu_src_a     = w_aluSrcA     & w_run;
  assign o_alu_src_b     = w_aluSrcB     & {2{w_run}};
  assign o_alu_op        = w_aluOp       & {3{w_run}};
  assign o_pc_source     = w_pcSource    & {2{w_run}};
  assign o_instr_done    = w_instrDone   & w_run;
  assign o_illegal_op    = w_illegalOp   & w_run;
  assign o_state         = r_state       & {4{w_run}};

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Directed-vector bench for the multi-cycle MIPS control FSM. Inputs change 1ns
// after each rising edge, and outputs are sampled on the falling edge. The
// expected control word for each cycle comes from the behaviour table of the
// control unit. The expected state sequence is listed by hand.
// The addi expectations follow CTRL_ADDI_EN in the same way as the design.

module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       memReady;

  logic       pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, instrDone, illegalOp;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] aluOp;
  logic [3:0] stateObs;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6,
    S_EXEC = 4'd7, S_R_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10,
    S_ADDI_EX = 4'd11, S_ADDI_WB = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

  mips_multicycle_control dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_opcode        (opcode),
    .i_mem_ready     (memReady),
    .o_pc_write      (pcWrite),
    .o_pc_write_cond (pcWriteCond),
    .o_i_or_d        (iOrD),
    .o_mem_read      (memRead),
    .o_mem_write     (memWrite),
    .o_ir_write      (irWrite),
    .o_mem_to_reg    (memToReg),
    .o_reg_dst       (regDst),
    .o_reg_write     (regWrite),
    .o_alu_src_a     (aluSrcA),
    .o_alu_src_b     (aluSrcB),
    .o_alu_op        (aluOp),
    .o_pc_source     (pcSource),
    .o_instr_done    (instrDone),
    .o_illegal_op    (illegalOp),
    .o_state         (stateObs)
  );

  // 10ns clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word layout:
  // {pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, memToReg, regDst,
  //  regWrite, aluSrcA, aluSrcB[1:0], aluOp[2:0], pcSource[1:0], instrDone, illegalOp}
  function automatic logic [18:0] expCtrl(input logic [3:0] st, input logic mr,
                                          input logic rst, input logic [5:0] op);
    logic [18:0] w;
    w = '0;
    if (!rst) begin
      case (st)
        S_FETCH:    w = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 3'b000, 1'b0, 2'b01, 3'b000, 2'b00, 2'b00};
        S_DECODE: begin
          w = {10'b0, 2'b11, 3'b000, 2'b00, 2'b00};
`ifdef CTRL_ADDI_EN
          w[0] = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
`else
          w[0] = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J});
`endif
        end
        S_MEM_ADDR: w = {9'b0, 1'b1, 2'b10, 3'b000, 2'b00, 2'b00};
        S_MEM_RD:   w = {2'b00, 1'b1, 1'b1, 15'b0};
        S_MEM_WB:   w = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b10};
        S_MEM_WR:   w = {2'b00, 1'b1, 1'b0, 1'b1, 12'b0, mr, 1'b0};
        S_EXEC:     w = {9'b0, 1'b1, 2'b00, 3'b010, 2'b00, 2'b00};
        S_R_WB:     w = {6'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b10};
        S_BRANCH:   w = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 3'b001, 2'b01, 2'b10};
        S_JUMP:     w = {1'b1, 9'b0, 2'b00, 3'b000, 2'b10, 2'b10};
        S_ADDI_EX:  w = {9'b0, 1'b1, 2'b10, 3'b000, 2'b00, 2'b00};
        S_ADDI_WB:  w = {8'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b10};
        default:    w = '0;
      endcase
    end
    return w;
  endfunction

  // Count one comparison and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then check state and controls on the falling edge
  task automatic applyStimulus(input logic rst, input logic mr, input logic [5:0] op,
                               input logic [3:0] expState, input string tag);
    logic [18:0] obs;
    @(posedge clk);
    #1;
    reset    = rst;
    memReady = mr;
    opcode   = op;
    @(negedge clk);
    obs = {pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, memToReg, regDst,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp};
    checkOutput({tag, "/state"}, {28'b0, stateObs}, {28'b0, (rst ? S_RST : expState)});
    checkOutput({tag, "/ctrl"}, {13'b0, obs}, {13'b0, expCtrl(expState, mr, rst, op)});
  endtask

  initial begin
    reset    = 1'b1;
    memReady = 1'b1;
    opcode   = OP_R;

    // Hold reset for two cycles, release it, spend one cycle in S_RST, then enter FETCH
    applyStimulus(1, 1, OP_R, S_RST, "rst0");
    applyStimulus(1, 1, OP_R, S_RST, "rst1");
    applyStimulus(0, 1, OP_R, S_RST, "srst");
    applyStimulus(0, 1, OP_R, S_FETCH, "r_fetch");

    // R-type: states 1, 2, 7, 8
    applyStimulus(0, 1, OP_R, S_DECODE, "r_dec");
    applyStimulus(0, 1, OP_R, S_EXEC, "r_exec");
    applyStimulus(0, 1, OP_R, S_R_WB, "r_wb");

    // lw with two stall cycles in MEM_RD: 7 cycles from FETCH through MEM_WB
    applyStimulus(0, 1, OP_LW, S_FETCH, "lw_fetch");
    applyStimulus(0, 1, OP_LW, S_DECODE, "lw_dec");
    applyStimulus(0, 1, OP_LW, S_MEM_ADDR, "lw_addr");
    applyStimulus(0, 0, OP_LW, S_MEM_RD, "lw_rd0");
    applyStimulus(0, 0, OP_LW, S_MEM_RD, "lw_rd1");
    applyStimulus(0, 1, OP_LW, S_MEM_RD, "lw_rd2");
    applyStimulus(0, 1, OP_LW, S_MEM_WB, "lw_wb");

    // Fetch stall, then sw with one stall cycle in MEM_WR
    applyStimulus(0, 0, OP_SW, S_FETCH, "sw_fstall");
    applyStimulus(0, 1, OP_SW, S_FETCH, "sw_fetch");
    applyStimulus(0, 1, OP_SW, S_DECODE, "sw_dec");
    applyStimulus(0, 1, OP_SW, S_MEM_ADDR, "sw_addr");
    applyStimulus(0, 0, OP_SW, S_MEM_WR, "sw_wr0");
    applyStimulus(0, 1, OP_SW, S_MEM_WR, "sw_wr1");

    // beq, with mem_ready low in DECODE and BRANCH, where it must be ignored
    applyStimulus(0, 1, OP_BEQ, S_FETCH, "beq_fetch");
    applyStimulus(0, 0, OP_BEQ, S_DECODE, "beq_dec");
    applyStimulus(0, 0, OP_BEQ, S_BRANCH, "beq_br");

    // j
    applyStimulus(0, 1, OP_J, S_FETCH, "j_fetch");
    applyStimulus(0, 1, OP_J, S_DECODE, "j_dec");
    applyStimulus(0, 1, OP_J, S_JUMP, "j_jump");

    // Illegal opcode: illegal_op pulses in DECODE and control returns to FETCH
    applyStimulus(0, 1, OP_BAD, S_FETCH, "bad_fetch");
    applyStimulus(0, 1, OP_BAD, S_DECODE, "bad_dec");

    // addi: executes when CTRL_ADDI_EN is defined, otherwise it is illegal
    applyStimulus(0, 1, OP_ADDI, S_FETCH, "addi_fetch");
    applyStimulus(0, 1, OP_ADDI, S_DECODE, "addi_dec");
`ifdef CTRL_ADDI_EN
    applyStimulus(0, 1, OP_ADDI, S_ADDI_EX, "addi_ex");
    applyStimulus(0, 1, OP_ADDI, S_ADDI_WB, "addi_wb");
`endif

    // Reset asserted during MEM_WR: outputs go to 0 at once, and S_RST follows on the next edge
    applyStimulus(0, 1, OP_SW, S_FETCH, "rsw_fetch");
    applyStimulus(0, 1, OP_SW, S_DECODE, "rsw_dec");
    applyStimulus(0, 1, OP_SW, S_MEM_ADDR, "rsw_addr");
    applyStimulus(0, 0, OP_SW, S_MEM_WR, "rsw_wr");
    applyStimulus(1, 0, OP_SW, S_MEM_WR, "rsw_rst");
    applyStimulus(0, 1, OP_SW, S_RST, "rsw_srst");
    applyStimulus(0, 1, OP_R, S_FETCH, "rsw_fetch2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
